// File: rtl/loteria_pkg.sv
// Shared types and scoring helpers for the multi-ticket lottery checker.
package loteria_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        SCORE  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    localparam logic [1:0] PREMIO_NONE = 2'b00;
    localparam logic [1:0] PREMIO_P1   = 2'b01;
    localparam logic [1:0] PREMIO_P2   = 2'b10;

    // Tier earned by a leading consecutive-match run.
    function automatic logic [1:0] premio_tier(input int unsigned run,
                                               input int unsigned p1_min,
                                               input int unsigned p2_min);
        if (run >= p1_min)      return PREMIO_P1;
        else if (run >= p2_min) return PREMIO_P2;
        else                    return PREMIO_NONE;
    endfunction

    // One-step promotion; a near-miss run can lift NONE into prize 2.
    function automatic logic [1:0] premio_promote(input logic [1:0] tier,
                                                  input logic       near_p2);
        if (tier == PREMIO_P2)        return PREMIO_P1;
        else if (tier == PREMIO_NONE) return near_p2 ? PREMIO_P2 : PREMIO_NONE;
        else                          return tier;
    endfunction

endpackage

// File: rtl/loteria_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the prize totals.
module loteria_sat_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/loteria_multi_jogo.sv
// Lottery ticket checker: scores N-digit tickets against a loadable draw by leading-match run.
// Optional LOTERIA_LAST_DIGIT_BONUS_EN promotes well-formed tickets whose last digit matches.
module loteria_multi_jogo
    import loteria_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 5,
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned MAX_JOGOS = 5,
    parameter int unsigned P1_MIN    = 4,
    parameter int unsigned P2_MIN    = 2,
    parameter logic [N_DIGITS*DIGIT_W-1:0] DRAW_INIT = 20'h53820
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [DIGIT_W-1:0]             numero,
    input  logic                           insere,
    input  logic                           fim_jogo,
    input  logic                           fim,
    input  logic                           sorteio_we,
    input  logic [$clog2(N_DIGITS)-1:0]    sorteio_idx,
    input  logic [DIGIT_W-1:0]             sorteio_dado,
    output logic [1:0]                     premio,
    output logic                           premio_valid,
    output logic                           erro,
    output logic [CNT_W-1:0]               p1,
    output logic [CNT_W-1:0]               p2,
    output logic [$clog2(MAX_JOGOS+1)-1:0] jogos,
    output logic                           locked
);

    localparam int unsigned CNT_DW = $clog2(N_DIGITS + 2);
    localparam int unsigned RUN_W  = $clog2(N_DIGITS + 1);
    localparam int unsigned JOG_W  = $clog2(MAX_JOGOS + 1);
    localparam int unsigned DRAW_W = N_DIGITS * DIGIT_W;

    state_e              state_q, state_d;
    logic [DRAW_W-1:0]   draw_q, draw_d;
    logic [CNT_DW-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                match_q, match_d;
    logic [1:0]          premio_q, premio_d;
    logic                valid_q, valid_d;
    logic                erro_q, erro_d;
    logic [JOG_W-1:0]    jogos_q, jogos_d;
    logic                locked_q, locked_d;
    logic                p1_inc, p2_inc;
    logic [1:0]          tier_c;
    logic [DIGIT_W-1:0]  draw_digit_c;
    logic                digit_eq_c;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
    logic                last_eq_q, last_eq_d;
`endif

    // Draw digit addressed by the current ticket position (digit 0 in the MSBs).
    always_comb begin
        draw_digit_c = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (int'(cnt_q) == i) draw_digit_c = draw_q[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
    assign digit_eq_c = (numero == draw_digit_c);

    always_comb begin
        state_d  = state_q;
        draw_d   = draw_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        match_d  = match_q;
        premio_d = premio_q;
        valid_d  = 1'b0;
        erro_d   = erro_q;
        jogos_d  = jogos_q;
        p1_inc   = 1'b0;
        p2_inc   = 1'b0;
        tier_c   = PREMIO_NONE;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
        last_eq_d = last_eq_q;
`endif

        if (sorteio_we && (state_q == IDLE || state_q == LOCKED)) begin
            for (int i = 0; i < N_DIGITS; i++)
                if (int'(sorteio_idx) == i) draw_d[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sorteio_dado;
        end

        case (state_q)
            IDLE, ENTRY: begin
                if (insere) begin
                    if (cnt_q < CNT_DW'(N_DIGITS)) begin
                        if (match_q && digit_eq_c) run_d = run_q + RUN_W'(1);
                        else                       match_d = 1'b0;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
                        if (cnt_q == CNT_DW'(N_DIGITS - 1)) last_eq_d = digit_eq_c;
`endif
                    end
                    // Count saturates one past a full ticket to flag overlong entries.
                    if (cnt_q <= CNT_DW'(N_DIGITS)) cnt_d = cnt_q + CNT_DW'(1);
                    if (state_q == IDLE) state_d = ENTRY;
                end
                if (fim_jogo && (state_q == ENTRY || insere)) state_d = SCORE;
            end
            SCORE: begin
                valid_d = 1'b1;
                jogos_d = jogos_q + JOG_W'(1);
                if (cnt_q != CNT_DW'(N_DIGITS)) begin
                    premio_d = PREMIO_NONE;
                    erro_d   = 1'b1;
                end else begin
                    tier_c = premio_tier(32'(run_q), P1_MIN, P2_MIN);
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
                    if (last_eq_q) tier_c = premio_promote(tier_c, (32'(run_q) + 32'd1) >= P2_MIN);
`endif
                    premio_d = tier_c;
                    erro_d   = 1'b0;
                    p1_inc   = (tier_c == PREMIO_P1);
                    p2_inc   = (tier_c == PREMIO_P2);
                end
                state_d = (jogos_q + JOG_W'(1) == JOG_W'(MAX_JOGOS)) ? LOCKED : IDLE;
                cnt_d   = '0;
                run_d   = '0;
                match_d = 1'b1;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
                last_eq_d = 1'b0;
`endif
            end
            LOCKED: begin
            end
            default: state_d = IDLE;
        endcase

        // Session clear wins over everything but keeps the last result visible.
        if (fim) begin
            state_d  = IDLE;
            cnt_d    = '0;
            run_d    = '0;
            match_d  = 1'b1;
            jogos_d  = '0;
            valid_d  = 1'b0;
            premio_d = premio_q;
            erro_d   = erro_q;
            p1_inc   = 1'b0;
            p2_inc   = 1'b0;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
            last_eq_d = 1'b0;
`endif
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            draw_q   <= DRAW_INIT;
            cnt_q    <= '0;
            run_q    <= '0;
            match_q  <= 1'b1;
            premio_q <= PREMIO_NONE;
            valid_q  <= 1'b0;
            erro_q   <= 1'b0;
            jogos_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            draw_q   <= draw_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            match_q  <= match_d;
            premio_q <= premio_d;
            valid_q  <= valid_d;
            erro_q   <= erro_d;
            jogos_q  <= jogos_d;
            locked_q <= locked_d;
        end
    end

`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) last_eq_q <= 1'b0;
        else          last_eq_q <= last_eq_d;
    end
`endif

    loteria_sat_counter #(.CNT_W(CNT_W)) u_p1 (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (fim),
        .inc_i  (p1_inc),
        .cnt_o  (p1)
    );

    loteria_sat_counter #(.CNT_W(CNT_W)) u_p2 (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (fim),
        .inc_i  (p2_inc),
        .cnt_o  (p2)
    );

    assign premio       = premio_q;
    assign premio_valid = valid_q;
    assign erro         = erro_q;
    assign jogos        = jogos_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_loteria_multi_jogo.sv
// Scoreboard bench for loteria_multi_jogo: randomized tickets checked against a ticket-level model.
module tb_loteria_multi_jogo;

    localparam int N  = 5;
    localparam int W  = 4;
    localparam int CW = 2;
    localparam int MJ = 5;
    localparam int P1 = 4;
    localparam int P2 = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset_n;
    logic [W-1:0] numero;
    logic insere, fim_jogo, fim, sorteio_we;
    logic [2:0] sorteio_idx;
    logic [W-1:0] sorteio_dado;
    logic [1:0] premio;
    logic premio_valid, erro, locked;
    logic [CW-1:0] p1, p2;
    logic [2:0] jogos;

    loteria_multi_jogo #(.CNT_W(CW), .MAX_JOGOS(MJ)) dut (
        .clock(clock), .reset_n(reset_n), .numero(numero), .insere(insere),
        .fim_jogo(fim_jogo), .fim(fim), .sorteio_we(sorteio_we),
        .sorteio_idx(sorteio_idx), .sorteio_dado(sorteio_dado),
        .premio(premio), .premio_valid(premio_valid), .erro(erro),
        .p1(p1), .p2(p2), .jogos(jogos), .locked(locked)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] premio;
        logic       erro;
        int         p1;
        int         p2;
        int         jogos;
        logic       locked;
        longint     cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    int         draw_m[N];
    int         p1_m, p2_m, jogos_m;
    bit         locked_m;
    logic [1:0] premio_m;
    bit         erro_m;
    int         tkt[$];

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        draw_m = '{5, 3, 8, 2, 0};
        p1_m = 0; p2_m = 0; jogos_m = 0; locked_m = 0;
        premio_m = 2'b00; erro_m = 0;
    endtask

    // Score the ticket held in tkt from the rules: leading-run length, malformed length, tiers.
    task automatic model_score();
        int  run;
        bit  still;
        int  lvl;
        exp_t e;
        if (locked_m || tkt.size() == 0) return;
        run = 0; still = 1;
        for (int i = 0; i < N && i < tkt.size(); i++) begin
            if (still && tkt[i] == draw_m[i]) run++;
            else still = 0;
        end
        if (tkt.size() != N) begin
            premio_m = 2'b00; erro_m = 1;
        end else begin
            erro_m = 0;
            lvl = (run >= P1) ? 2 : (run >= P2) ? 1 : 0;
`ifdef LOTERIA_LAST_DIGIT_BONUS_EN
            if (tkt[N-1] == draw_m[N-1]) begin
                if (lvl > 0) lvl = 2;
                else if (run >= P2 - 1) lvl = 1;
            end
`endif
            premio_m = (lvl == 2) ? 2'b01 : (lvl == 1) ? 2'b10 : 2'b00;
            if (lvl == 2 && p1_m < CMAX) p1_m++;
            if (lvl == 1 && p2_m < CMAX) p2_m++;
        end
        jogos_m++;
        locked_m = (jogos_m == MJ);
        e.premio = premio_m; e.erro = erro_m; e.p1 = p1_m; e.p2 = p2_m;
        e.jogos = jogos_m; e.locked = locked_m; e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest expected result, on the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && premio_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", premio_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("premio", premio, e.premio);
                    chk("erro", erro, e.erro);
                    chk("p1", p1, e.p1);
                    chk("p2", p2, e.p2);
                    chk("jogos", jogos, e.jogos);
                    chk("locked", locked, e.locked);
                    chk("valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic play(input bit together);
        for (int i = 0; i < tkt.size(); i++) begin
            @(negedge clock);
            numero   = W'(tkt[i]);
            insere   = 1'b1;
            fim_jogo = together && (i == tkt.size() - 1);
            if (fim_jogo) model_score();
        end
        if (!together || tkt.size() == 0) begin
            @(negedge clock);
            insere   = 1'b0;
            fim_jogo = 1'b1;
            model_score();
        end
        @(negedge clock);
        insere   = 1'b0;
        fim_jogo = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic write_draw(input int idx, input int val);
        @(negedge clock);
        sorteio_we = 1'b1; sorteio_idx = 3'(idx); sorteio_dado = W'(val);
        @(negedge clock);
        sorteio_we = 1'b0;
        if (idx < N) draw_m[idx] = val;
    endtask

    task automatic do_fim();
        @(negedge clock);
        fim = 1'b1;
        @(negedge clock);
        fim = 1'b0;
        p1_m = 0; p2_m = 0; jogos_m = 0; locked_m = 0;
        chk("fim_p1", p1, 0);
        chk("fim_p2", p2, 0);
        chk("fim_jogos", jogos, 0);
        chk("fim_locked", locked, 0);
        chk("fim_premio_held", premio, premio_m);
        chk("fim_erro_held", erro, erro_m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_premio"}, premio, 0);
        chk({tag, "_valid"}, premio_valid, 0);
        chk({tag, "_erro"}, erro, 0);
        chk({tag, "_p1"}, p1, 0);
        chk({tag, "_p2"}, p2, 0);
        chk({tag, "_jogos"}, jogos, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int len;
        reset_n = 1'b0; numero = '0; insere = 0; fim_jogo = 0; fim = 0;
        sorteio_we = 0; sorteio_idx = '0; sorteio_dado = '0;
        model_reset();
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed tickets against the reset draw 5,3,8,2,0.
        tkt = {};                play(0);
        tkt = '{5, 3, 8, 2, 0};  play(0);
        tkt = '{5, 3, 1, 2, 0};  play(1);
        tkt = '{9, 3, 8, 2, 0};  play(0);
        tkt = '{5, 3, 8};        play(1);
        tkt = '{5, 3, 8, 2, 0, 1}; play(0);
        chk("lock_jogos", jogos, MJ);
        chk("lock_flag", locked, 1);
        tkt = '{5, 3, 8, 2, 0};  play(0);
        chk("locked_jogos_held", jogos, MJ);
        chk("locked_p1_held", p1, p1_m);
        do_fim();

        // Prize-1 saturation, then draw rewrite (idx 6 must be ignored).
        for (int k = 0; k < 4; k++) begin
            tkt = '{5, 3, 8, 2, 0}; play(k % 2);
        end
        chk("sat_p1", p1, CMAX);
        write_draw(2, 7);
        write_draw(6, 9);
        tkt = '{5, 3, 7, 2, 0}; play(0);
        chk("sat_p1_after", p1, CMAX);
        do_fim();

        // Randomized tickets, draws and session clears.
        for (int it = 0; it < 60; it++) begin
            if (locked_m && $urandom_range(0, 1) == 1) do_fim();
            if ($urandom_range(0, 5) == 0)
                write_draw($urandom_range(0, 7), $urandom_range(0, 9));
            len = ($urandom_range(0, 9) < 6) ? N : $urandom_range(0, 7);
            tkt = {};
            for (int i = 0; i < len; i++) begin
                if (i < N && $urandom_range(0, 3) != 0) tkt.push_back(draw_m[i]);
                else tkt.push_back($urandom_range(0, 15));
            end
            play($urandom_range(0, 1));
        end
        if (locked_m) do_fim();

        // Ensure a non-zero result is showing, then reset mid-ticket.
        tkt = '{5, 3, 1, 2, 0};
        for (int i = 0; i < N; i++) tkt[i] = draw_m[i];
        play(0);
        @(negedge clock);
        insere = 1'b1; numero = W'(draw_m[0]);
        @(negedge clock);
        numero = W'(draw_m[1]);
        #2 reset_n = 1'b0; insere = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        tkt = '{5, 3, 1, 2, 0}; play(0);

        repeat (4) @(negedge clock);
        chk("pending_results", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
